// File: rtl/sync_toggle_rx.sv
// Destination side of a toggle-handshake CDC: captures the sender's bus on a
// request toggle, offers it valid/ready downstream, and returns a toggle ack.
//
// state | meaning
// IDLE  | no payload held; waiting for a request toggle
// HOLD  | payload presented on dout_pd with dout_pvld=1
module sync_toggle_rx #(
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          clr_,
  input  logic          req_sync,
  input  logic [DW-1:0] src_data,
  output logic          ack,
  output logic          dout_pvld,
  input  logic          dout_prdy,
  output logic [DW-1:0] dout_pd,
  output logic          err,
  output logic [CW-1:0] stall_cnt
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HOLD = 1'b1;
  localparam logic [CW-1:0] STALL_MAX = '1;

  logic state;
  logic req_d;
  logic req_edge;

  assign req_edge = req_sync ^ req_d;

  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      state     <= ST_IDLE;
      req_d     <= 1'b0;
      ack       <= 1'b0;
      dout_pvld <= 1'b0;
      dout_pd   <= '0;
      err       <= 1'b0;
      stall_cnt <= '0;
    end else begin
      req_d <= req_sync;
      if (state == ST_IDLE) begin
        if (req_edge) begin
          dout_pd   <= src_data;
          dout_pvld <= 1'b1;
          state     <= ST_HOLD;
        end
      end else begin
        // A toggle while a payload is still held is dropped, even on the accept cycle.
        if (req_edge) begin
          err <= 1'b1;
        end
        if (dout_prdy) begin
          dout_pvld <= 1'b0;
          ack       <= ~ack;
          stall_cnt <= '0;
          state     <= ST_IDLE;
        end else if (stall_cnt != STALL_MAX) begin
          stall_cnt <= stall_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_toggle_rx.sv
// Self-checking bench for sync_toggle_rx: directed scenarios plus random traffic
// against a transaction-level model; a CW=3 copy watches stall saturation.
module tb_sync_toggle_rx;

  localparam int DW = 32;
  localparam int CW = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          clr_ = 1'b0;
  logic          req_sync = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          dout_prdy = 1'b0;
  logic          ack, dout_pvld, err;
  logic [DW-1:0] dout_pd;
  logic [CW-1:0] stall_cnt;
  logic          s_ack, s_dout_pvld, s_err;
  logic [DW-1:0] s_dout_pd;
  logic [SW-1:0] s_stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sync_toggle_rx #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .clr_(clr_), .req_sync(req_sync), .src_data(src_data),
    .ack(ack), .dout_pvld(dout_pvld), .dout_prdy(dout_prdy),
    .dout_pd(dout_pd), .err(err), .stall_cnt(stall_cnt)
  );

  sync_toggle_rx #(.DW(DW), .CW(SW)) dut_sat (
    .clk(clk), .clr_(clr_), .req_sync(req_sync), .src_data(src_data),
    .ack(s_ack), .dout_pvld(s_dout_pvld), .dout_prdy(dout_prdy),
    .dout_pd(s_dout_pd), .err(s_err), .stall_cnt(s_stall_cnt)
  );

  // Transaction-level reference: is a payload outstanding, which one, how
  // many were accepted, has a protocol violation happened, how long it waited.
  logic          m_last_req;
  logic          m_busy;
  logic [DW-1:0] m_data;
  int            m_accepted;
  logic          m_err;
  int            m_wait;

  always @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      m_last_req <= 1'b0;
      m_busy     <= 1'b0;
      m_data     <= '0;
      m_accepted <= 0;
      m_err      <= 1'b0;
      m_wait     <= 0;
    end else begin
      m_last_req <= req_sync;
      if (m_busy) begin
        if (req_sync != m_last_req) m_err <= 1'b1;
        if (dout_prdy) begin
          m_busy     <= 1'b0;
          m_accepted <= m_accepted + 1;
          m_wait     <= 0;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else if (req_sync != m_last_req) begin
        m_busy <= 1'b1;
        m_data <= src_data;
      end
    end
  end

  function automatic logic [DW+CW+2:0] exp_main();
    logic [CW-1:0] st;
    st = (m_wait >= (1 << CW) - 1) ? CW'((1 << CW) - 1) : CW'(m_wait);
    return {m_busy, m_data, m_accepted[0], m_err, st};
  endfunction

  function automatic logic [SW-1:0] exp_sat();
    return (m_wait >= (1 << SW) - 1) ? SW'((1 << SW) - 1) : SW'(m_wait);
  endfunction

  logic [DW-1:0] got_q[$];
  always @(posedge clk) begin
    if (clr_ && dout_pvld && dout_prdy) got_q.push_back(dout_pd);
  end

  task automatic apply_reset();
    clr_ = 1'b0;
    req_sync = 1'b0;
    dout_prdy = 1'b0;
    repeat (2) @(negedge clk);
    clr_ = 1'b1;
  endtask

  task automatic test_reset();
    clr_ = 1'b0;
    req_sync = 1'b0;
    #1;
    n_tests++;
    if ({dout_pvld, dout_pd, ack, err, stall_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %h required 0", {dout_pvld, dout_pd, ack, err, stall_cnt});
    end
    apply_reset();
  endtask

  task automatic test_basic();
    apply_reset();
    @(negedge clk);
    src_data = 32'hA5A5A5A5; dout_prdy = 1'b1; req_sync = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({dout_pvld, dout_pd, ack, stall_cnt} !== {1'b1, 32'hA5A5A5A5, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL basic_capture: got pvld=%b pd=%h ack=%b st=%0d required 1 a5a5a5a5 0 0",
               dout_pvld, dout_pd, ack, stall_cnt);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({dout_pvld, ack, stall_cnt} !== {1'b0, 1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL basic_ack: got pvld=%b ack=%b st=%0d required 0 1 0", dout_pvld, ack, stall_cnt);
    end
    repeat (3) begin
      @(posedge clk); #1;
      n_tests++;
      if ({dout_pvld, dout_pd, ack, err, stall_cnt} !== exp_main()) begin
        n_fail++;
        $display("FAIL basic_idle: got %h required %h", {dout_pvld, dout_pd, ack, err, stall_cnt}, exp_main());
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d;
    apply_reset();
    d = $urandom;
    @(negedge clk);
    src_data = d; dout_prdy = 1'b0; req_sync = ~req_sync;
    @(posedge clk); #1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({dout_pvld, dout_pd, stall_cnt} !== {1'b1, d, CW'(i)}) begin
        n_fail++;
        $display("FAIL backpressure_wait: got pvld=%b pd=%h st=%0d required 1 %h %0d",
                 dout_pvld, dout_pd, stall_cnt, d, i);
      end
    end
    @(negedge clk); dout_prdy = 1'b1; src_data = ~d;
    @(posedge clk); #1;
    n_tests++;
    if ({dout_pvld, ack, stall_cnt} !== {1'b0, 1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL backpressure_accept: got pvld=%b ack=%b st=%0d required 0 1 0", dout_pvld, ack, stall_cnt);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    @(negedge clk);
    src_data = $urandom; dout_prdy = 1'b0; req_sync = ~req_sync;
    @(posedge clk); #1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (s_stall_cnt !== exp_sat() || stall_cnt !== CW'(i)) begin
        n_fail++;
        $display("FAIL saturation: cycle %0d got sat=%0d wide=%0d required %0d %0d",
                 i, s_stall_cnt, stall_cnt, exp_sat(), i);
      end
    end
    n_tests++;
    if (s_stall_cnt !== 3'd7) begin
      n_fail++;
      $display("FAIL saturation_final: got %0d required 7", s_stall_cnt);
    end
  endtask

  task automatic test_violation();
    logic [DW-1:0] d;
    apply_reset();
    d = $urandom;
    @(negedge clk);
    src_data = d; dout_prdy = 1'b0; req_sync = ~req_sync;
    @(posedge clk); #1;
    @(negedge clk);
    src_data = ~d; req_sync = ~req_sync;
    @(posedge clk); #1;
    n_tests++;
    if ({err, dout_pvld, dout_pd} !== {1'b1, 1'b1, d}) begin
      n_fail++;
      $display("FAIL violation_flag: got err=%b pvld=%b pd=%h required 1 1 %h", err, dout_pvld, dout_pd, d);
    end
    @(negedge clk); dout_prdy = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      n_tests++;
      if ({err, dout_pvld, ack} !== 3'b101) begin
        n_fail++;
        $display("FAIL violation_after: got err=%b pvld=%b ack=%b required 1 0 1", err, dout_pvld, ack);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] sent[$];
    apply_reset();
    got_q.delete();
    @(negedge clk); dout_prdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      src_data = $urandom; sent.push_back(src_data); req_sync = ~req_sync;
      repeat (2) begin
        @(posedge clk); #1;
        n_tests++;
        if ({dout_pvld, dout_pd, ack, err, stall_cnt} !== exp_main()) begin
          n_fail++;
          $display("FAIL back_to_back_cycle: got %h required %h", {dout_pvld, dout_pd, ack, err, stall_cnt}, exp_main());
        end
      end
    end
    n_tests++;
    if (got_q.size() != 4 || {ack, err} !== 2'b00) begin
      n_fail++;
      $display("FAIL back_to_back_end: got %0d payloads ack=%b err=%b required 4 0 0", got_q.size(), ack, err);
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== sent[i]) begin
        n_fail++;
        $display("FAIL back_to_back_order: payload %0d got %h required %h", i, got_q[i], sent[i]);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    apply_reset();
    @(negedge clk);
    src_data = $urandom; dout_prdy = 1'b0; req_sync = ~req_sync;
    repeat (2) @(posedge clk);
    #2;
    clr_ = 1'b0;
    #1;
    n_tests++;
    if ({dout_pvld, dout_pd, ack, err, stall_cnt, s_stall_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_hold: got pvld=%b pd=%h ack=%b err=%b st=%0d required all 0",
               dout_pvld, dout_pd, ack, err, stall_cnt);
    end
    req_sync = 1'b0;
    @(negedge clk); clr_ = 1'b1; dout_prdy = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      n_tests++;
      if ({dout_pvld, ack} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_mid_hold_after: got pvld=%b ack=%b required 0 0", dout_pvld, ack);
      end
    end
  endtask

  task automatic test_first_after_reset();
    logic [DW-1:0] d;
    d = $urandom;
    clr_ = 1'b0; dout_prdy = 1'b0;
    @(negedge clk);
    req_sync = 1'b1; src_data = d;
    @(negedge clk); clr_ = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({dout_pvld, dout_pd} !== {1'b1, d}) begin
      n_fail++;
      $display("FAIL first_after_reset: got pvld=%b pd=%h required 1 %h", dout_pvld, dout_pd, d);
    end
  endtask

  task automatic test_random();
    int busy_pct;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (i % 60 == 0) busy_pct = $urandom_range(10, 90);
      if ($urandom_range(0, 3) == 0) begin
        req_sync = ~req_sync;
        src_data = $urandom;
      end else if ($urandom_range(0, 3) == 0) begin
        src_data = $urandom;
      end
      dout_prdy = ($urandom_range(0, 99) >= busy_pct);
      @(posedge clk); #1;
      n_tests++;
      if ({dout_pvld, dout_pd, ack, err, stall_cnt} !== exp_main() || s_stall_cnt !== exp_sat()) begin
        n_fail++;
        $display("FAIL random_cycle %0d: got %h/%0d required %h/%0d", i,
                 {dout_pvld, dout_pd, ack, err, stall_cnt}, s_stall_cnt, exp_main(), exp_sat());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_violation();
    test_back_to_back();
    test_reset_mid_hold();
    test_first_after_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
